binary_to_bcd_nbit: RTL

Sequential double-dabble converter that turns an unsigned binary value into DISPLAYS packed BCD digits, one nibble per seven-segment display. It sits directly upstream of the N-bit hex-to-seven-segment encoder. Its `bcd` output connects straight to the encoder's `hex` input, so numeric values show as decimal on the DE1-SoC displays. A conversion is started by a single-cycle request and completes in a fixed number of cycles.

---
 rtl/binary_to_bcd_nbit.sv | 76 +++++++
 1 files changed

// File: rtl/binary_to_bcd_nbit.sv
// binary_to_bcd_nbit: sequential double-dabble binary to packed BCD converter (optional BCD_SATURATE_EN forces all nines on overflow)
module binary_to_bcd_nbit #(
   parameter int DISPLAYS  = 6,
   parameter int BIN_WIDTH = 20,
   parameter int BCD_MSB   = (4 * DISPLAYS) - 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [BIN_WIDTH-1:0] binary,
   output logic                 busy,
   output logic                 done,
   output logic [BCD_MSB:0]     bcd,
   output logic                 overflow
);
   localparam int CW = $clog2(BIN_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
   state_t               state, state_next;
   logic [BIN_WIDTH-1:0] shift;
   logic [BCD_MSB:0]     scratch, adjusted, scratch_next, result;
   logic                 sticky, sticky_next, load, last;
   logic [CW-1:0]        cnt;
   assign load         = (state != CONVERT) && start;
   assign last         = cnt == CW'(1);
   assign scratch_next = {adjusted[BCD_MSB-1:0], shift[BIN_WIDTH-1]};
   assign sticky_next  = sticky | adjusted[BCD_MSB];
   assign busy         = state == CONVERT;
   assign done         = state == DONE;
`ifdef BCD_SATURATE_EN
   assign result = sticky_next ? {DISPLAYS{4'h9}} : scratch_next;
`else
   assign result = scratch_next;
`endif
   // add-3 correction on every scratch digit of 5 or more, no inter-digit carry
   always_comb begin
      adjusted = scratch;
      for (int i = 0; i < DISPLAYS; i++)
         adjusted[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
   end
   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end
   // next state: a start in IDLE or DONE launches a conversion, start is ignored while converting
   always_comb begin
      state_next = IDLE;
      if (state == CONVERT) state_next = last ? DONE : CONVERT;
      else                  state_next = start ? CONVERT : IDLE;
   end
   // datapath: capture on start, one shift per CONVERT cycle, publish result on the final iteration
   always_ff @(posedge clock) begin
      if (reset) begin
         shift    <= '0;
         scratch  <= '0;
         sticky   <= 1'b0;
         cnt      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else if (load) begin
         shift   <= binary;
         scratch <= '0;
         sticky  <= 1'b0;
         cnt     <= CW'(BIN_WIDTH);
      end else if (state == CONVERT) begin
         shift   <= shift << 1;
         scratch <= scratch_next;
         sticky  <= sticky_next;
         cnt     <= cnt - CW'(1);
         if (last) begin
            bcd      <= result;
            overflow <= sticky_next;
         end
      end
   end
endmodule
